hit_scan_display: RTL
=====================

Name: hit_scan_display

Overview:
- Downstream stage of the 1101 sequence detector.
- Consumes the detector's match level `z`, the serial bit `now` and the debounced step button.
- Keeps a BCD count of detections, a count of bits shifted and a 4-bit history of the last bits.
- Drives the board's 8-digit multiplexed seven-segment display at system clock rate.

Parameters:
- SCAN_DIV, 99999: clk cycles per digit slot minus 1 (100 MHz clk gives a 1 kHz digit rate).
- HIT_MAX, 99: highest BCD hit count; must be 1..99.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low; clears all state.
- step  in  1  debounced step-button level, asynchronous to clk.
- hit  in  1  detector match level (`z`), asynchronous.
- bit_in  in  1  current serial bit (`now`), asynchronous.
- load  in  1  parallel-load enable level (`set`), asynchronous.
- hit_cnt  out  8  BCD detection count: [7:4] tens, [3:0] units.
- bit_cnt  out  4  bits shifted since last load, 0..8.
- an  out  8  digit enables, active-low, one-hot.
- seg  out  7  segments, active-low, seg[6:0] = g,f,e,d,c,b,a.

Behaviour:
- Reset (rst=0): hit_cnt=8'h00, bit_cnt=0, history=4'b0000, scan index=0, divider=0, an=8'hFF, seg=7'h7F.
  - Synchronizer flops reset to 0, except step, which resets to 1 (button released).
  - Reset mid-scan blanks the display immediately.
- Input conditioning:
  - step, hit, bit_in and load each pass through a 2-flop synchronizer plus one history flop.
  - step_ev = falling edge of synced step, because the detector advances on button release.
  - hit_ev = rising edge of synced hit.
  - load_ev = rising edge of synced load.
  - Each event is a 1-cycle pulse, 3 cycles after the input pin changes.
- Bit tracking, evaluated on the cycle after the event:
  - load_ev: bit_cnt←0, history←0.
  - Else on step_ev: bit_cnt←bit_cnt+1, saturating at 8; history←{history[2:0], bit_in_sync}.
  - bit_in_sync is the value sampled on the step_ev cycle.
  - load_ev and step_ev in the same cycle: load wins.
- Hit counting:
  - On hit_ev: units+1. When units=9, units←0 and tens+1.
  - When hit_cnt=HIT_MAX, hit_cnt←00 (wrap).
  - Consecutive detections always produce distinct rising edges of hit, since the detector returns to a non-match state between matches; each hit_ev counts exactly once.
  - hit_ev and step_ev in the same cycle: both are applied.
  - load does not clear hit_cnt; only rst does.
- Scan:
  - The divider counts 0..SCAN_DIV, then reloads 0.
  - On reload, scan index advances by 1, wrapping 7→0.
  - an[i]=0 only for i = scan index.
  - an and seg are registered together, so there is no ghosting between digits.
- Digit map:
  - Digit 0: hit units.
  - Digit 1: hit tens.
  - Digit 2: blank.
  - Digit 3: bit_cnt.
  - Digits 4..7: history[0..3], shown as "0" or "1".
- Decode: hex 0-9 uses standard patterns (0=7'h40, 1=7'h79, 8=7'h00). Blank and codes >9 give 7'h7F.

Optional Feature:
- HIT_SAT_EN defined: hit_cnt saturates at HIT_MAX, and further hit_ev are ignored until rst.
- HIT_SAT_EN undefined: hit_cnt wraps to 00 after HIT_MAX.

Test Plan:
- Reset: hold rst=0 for 5 cycles with toggling inputs → an=8'hFF, seg=7'h7F, hit_cnt=00, bit_cnt=0 throughout; first digit enable appears SCAN_DIV+1 cycles after release.
- Step tracking: with SCAN_DIV=3, pulse load, then 4 step releases with bit_in=1,1,0,1 → bit_cnt=4, history=4'b1101; 6 more steps → bit_cnt holds at 8.
- Hit counting: 12 hit rising edges, each separated by a step release → hit_cnt=8'h12. Issue a load → hit_cnt stays 12, bit_cnt=0.
- Hit wrap: 100 hit edges → hit_cnt=00. With HIT_SAT_EN defined, the same stimulus gives hit_cnt=99.
- Simultaneous events:
  - load and step edges in the same cycle → bit_cnt=0, history=0.
  - hit and step edges in the same cycle → both hit_cnt and bit_cnt advance.
- Scan: SCAN_DIV=3, hit_cnt=07 → digit 0 active with seg=7'h78, digit 1 with seg=7'h40, digit 2 with seg=7'h7F. Each digit is active for 4 cycles; the 8-digit sequence repeats every 32 cycles.

Source files
------------

// File: rtl/hit_scan_display.sv
// hit_scan_display: output stage behind the 1101 sequence detector.
// Synchronizes the step/hit/bit/load levels and counts detections in BCD.
// Tracks the bits shifted since the last load, plus a 4-bit history of them.
// Multiplexes all of this onto an 8-digit active-low seven-segment display.
// Optional build macro HIT_SAT_EN: the hit count saturates at HIT_MAX instead of wrapping to 00.
module hit_scan_display #(
    parameter int unsigned SCAN_DIV = 99999,
    parameter int unsigned HIT_MAX  = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       hit,
    input  logic       bit_in,
    input  logic       load,
    output logic [7:0] hit_cnt,
    output logic [3:0] bit_cnt,
    output logic [7:0] an,
    output logic [6:0] seg
);

    localparam int unsigned DIV_W = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
    localparam logic [7:0]  HIT_TOP = {4'(HIT_MAX / 10), 4'(HIT_MAX % 10)};

    logic [2:0]       step_sh, hit_sh, load_sh;
    logic [1:0]       bin_sh;
    logic             step_ev, hit_ev, load_ev;
    logic [7:0]       hit_q;
    logic [3:0]       bits_q;
    logic [3:0]       hist_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       idx_q;
    logic [7:0]       an_q;
    logic [6:0]       seg_q;
    logic [3:0]       digit;
    logic [6:0]       seg_d;

    // Two-flop synchronizers plus one history flop for edge detection.
    // The step button idles released (high).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_sh <= '1;
            hit_sh  <= '0;
            load_sh <= '0;
            bin_sh  <= '0;
        end else begin
            step_sh <= {step_sh[1:0], step};
            hit_sh  <= {hit_sh[1:0], hit};
            load_sh <= {load_sh[1:0], load};
            bin_sh  <= {bin_sh[0], bit_in};
        end
    end

    assign step_ev = ~step_sh[1] &  step_sh[2];
    assign hit_ev  =  hit_sh[1]  & ~hit_sh[2];
    assign load_ev =  load_sh[1] & ~load_sh[2];

    // Bit count and shift history; a load clears both and wins over a step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bits_q <= '0;
            hist_q <= '0;
        end else if (load_ev) begin
            bits_q <= '0;
            hist_q <= '0;
        end else if (step_ev) begin
            if (bits_q != 4'd8)
                bits_q <= bits_q + 4'd1;
            hist_q <= {hist_q[2:0], bin_sh[1]};
        end
    end

    // BCD detection counter; at HIT_TOP it wraps, or holds when saturation is built in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q <= '0;
        end else if (hit_ev) begin
            if (hit_q == HIT_TOP) begin
`ifdef HIT_SAT_EN
                hit_q <= hit_q;
`else
                hit_q <= '0;
`endif
            end else if (hit_q[3:0] == 4'd9) begin
                hit_q <= {hit_q[7:4] + 4'd1, 4'd0};
            end else begin
                hit_q <= {hit_q[7:4], hit_q[3:0] + 4'd1};
            end
        end
    end

    // Select the value shown in the current scan slot (4'hF means blank).
    always_comb begin
        digit = 4'hF;
        case (idx_q)
            3'd0: digit = hit_q[3:0];
            3'd1: digit = hit_q[7:4];
            3'd2: digit = 4'hF;
            3'd3: digit = bits_q;
            3'd4: digit = {3'b000, hist_q[0]};
            3'd5: digit = {3'b000, hist_q[1]};
            3'd6: digit = {3'b000, hist_q[2]};
            3'd7: digit = {3'b000, hist_q[3]};
            default: digit = 4'hF;
        endcase
    end

    // Active-low seven-segment decode, g..a; anything above 9 is blank.
    always_comb begin
        seg_d = 7'h7F;
        case (digit)
            4'd0: seg_d = 7'h40;
            4'd1: seg_d = 7'h79;
            4'd2: seg_d = 7'h24;
            4'd3: seg_d = 7'h30;
            4'd4: seg_d = 7'h19;
            4'd5: seg_d = 7'h12;
            4'd6: seg_d = 7'h02;
            4'd7: seg_d = 7'h78;
            4'd8: seg_d = 7'h00;
            4'd9: seg_d = 7'h10;
            default: seg_d = 7'h7F;
        endcase
    end

    // Scan divider. On each reload, an and seg both load the current slot and
    // the index advances, so the first digit lights SCAN_DIV+1 cycles after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            idx_q <= '0;
            an_q  <= '1;
            seg_q <= '1;
        end else if (div_q == DIV_W'(SCAN_DIV)) begin
            div_q <= '0;
            idx_q <= idx_q + 3'd1;
            an_q  <= ~(8'd1 << idx_q);
            seg_q <= seg_d;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign hit_cnt = hit_q;
    assign bit_cnt = bits_q;
    assign an      = an_q;
    assign seg     = seg_q;

endmodule
